ram_burst_ctrl: RTL
===================

# ram_burst_ctrl

Burst sequencer sitting directly upstream of the 1024 x 8 single-port RAM: it accepts a command (direction, base address, beat count), then streams write data into the RAM or read data out of it, one beat per clock. It is the only master of the RAM control pins, and it absorbs the RAM's negedge sampling so that host-side logic sees a plain posedge valid/ready interface.

## Interface
- ADDR_W, 10, RAM address width; burst addresses wrap modulo 2^ADDR_W
- DATA_W, 8, RAM data width
- clk  in  1  system clock; all controller flops are posedge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command; high only in IDLE
- cmd_rw  in  1  0 = write burst, 1 = read burst (same encoding as the RAM rw pin)
- cmd_addr  in  ADDR_W  first beat address
- cmd_len  in  ADDR_W  beat count minus one (0 = 1 beat, 1023 = 1024 beats)
- wr_valid  in  1  write beat present
- wr_ready  out  1  controller accepts write beat (high in WRITE state)
- wr_data  in  DATA_W  write beat data
- rd_valid  out  1  rd_data holds a read beat this cycle; no backpressure
- rd_data  out  DATA_W  read beat data
- busy  out  1  burst in progress (state != IDLE)
- done  out  1  one-cycle pulse at burst completion
- ram_en  out  1  RAM enable
- ram_rw  out  1  RAM direction, 0 write, 1 read
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM registered read data (undefined while ram_en = 0)

## Operation
- States: IDLE, WRITE, READ, FIN.
- IDLE: cmd_ready = 1. cmd_valid && cmd_ready at a posedge latches addr/len/rw, loads the beat counter with cmd_len, and moves to WRITE or READ.
- WRITE: wr_ready = 1. Each posedge with wr_valid registers ram_en = 1, ram_rw = 0, ram_addr = current address, ram_wdata = wr_data. The current address then increments and the counter decrements. A posedge without wr_valid registers ram_en = 0 (a gap; no RAM access). Accepting the final beat moves to FIN.
- READ: ram_en = 1, ram_rw = 1, ram_addr = current address on cmd_len + 1 consecutive cycles, with no stalls. Issuing the final address moves to FIN.
- FIN: lasts one cycle. At its closing posedge: ram_en <= 0, done <= 1, state <= IDLE.
- Read capture: at every posedge where the previous cycle had ram_en && ram_rw, set rd_valid <= 1 and rd_data <= ram_rdata. Otherwise rd_valid <= 0, and rd_data holds its last value; undefined RAM output is never captured.
- Address arithmetic: ADDR_W-bit increment with natural wrap; 1023 + 1 = 0.
- cmd_valid while busy is ignored, because cmd_ready = 0.
- wr_valid outside WRITE is ignored, because wr_ready = 0.

## Timing
- Reset values (asynchronous): state IDLE, cmd_ready 1, wr_ready 0, busy 0, done 0, rd_valid 0, rd_data 0, ram_en 0, ram_rw 1, ram_addr 0, ram_wdata 0.
- All RAM pins are registered at posedge and are stable half a cycle before the RAM's negedge sample.
- Write latency: a beat accepted at posedge P is written into the RAM at the negedge between P and P+1.
- Read latency: an address issued at posedge R has its data on rd_data/rd_valid from posedge R+1. Beats appear in address order on consecutive cycles.
- done is high in the cycle right after the last RAM-enabled cycle, with busy = 0 and cmd_ready = 1 in that same cycle.
  - For reads, done coincides with the last rd_valid.
  - For writes, done comes one cycle after the last write strobe.
- Command-to-first-RAM-access: 1 cycle for reads. For writes it is 1 cycle, or more if wr_valid is low.
- A new command presented during the done cycle is accepted; back-to-back bursts have no dead cycle beyond FIN.
- Reset mid-burst: ram_en drops immediately. Remaining beats are abandoned, with no done and no further rd_valid. Locations already written keep their data.

## Test plan
- Reset: assert rst_n = 0 mid-cycle -> all outputs at the listed reset values immediately; cmd_ready = 1 after release.
- Single beat: write addr 200, len 0, data 130; then read addr 200, len 0 -> rd_valid one cycle after ram_en, rd_data = 130, done exactly once per burst.
- Wrap with gaps: write addr 1022, len 3, data 1,2,3,4 with wr_valid toggling every other cycle -> ram_en high only on accepted beats, addrs 1022,1023,0,1. Read back -> 1,2,3,4 on four consecutive cycles.
- Full memory: write 1024 beats from addr 0 with data = addr[7:0] ^ 8'h5A, then read 1024 beats -> all match, 1024 rd_valid cycles, one done each.
- Reset during read addr 1000, len 7, asserted after beat 3 issued -> ram_en 0 and rd_valid 0 at once, no done. A subsequent read addr 1000, len 0 is accepted and returns the previously written value.
- Back-to-back: cmd_valid held through a 4-beat read -> ignored while busy, second command accepted in the done cycle. A command with cmd_rw = 0 pulsed while busy has no effect on the RAM.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl: burst sequencer in front of a single-port RAM that samples on negedge.
// Takes a command (direction, base address, beat count minus one) and then either
// accepts write beats over a valid/ready handshake or streams read beats out
// with a fixed one-cycle latency. All RAM pins come from posedge flops, so they are
// stable half a cycle before the RAM samples them.
module ram_burst_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rw,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;
    logic                ram_en_reg, ram_en_next;
    logic                ram_rw_reg, ram_rw_next;
    logic [ADDR_W-1:0]   ram_addr_reg, ram_addr_next;
    logic [DATA_W-1:0]   ram_wdata_reg, ram_wdata_next;
    logic                done_reg, done_next;
    logic                rd_valid_reg;
    logic [DATA_W-1:0]   rd_data_reg;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign wr_ready  = (state_reg == ST_WRITE);
    assign busy      = (state_reg != ST_IDLE);
    assign done      = done_reg;
    assign ram_en    = ram_en_reg;
    assign ram_rw    = ram_rw_reg;
    assign ram_addr  = ram_addr_reg;
    assign ram_wdata = ram_wdata_reg;
    assign rd_valid  = rd_valid_reg;
    assign rd_data   = rd_data_reg;

    // Next-state and next RAM-pin values; the RAM is idle unless a beat is issued this cycle.
    always_comb begin
        state_next     = state_reg;
        addr_next      = addr_reg;
        cnt_next       = cnt_reg;
        ram_en_next    = 1'b0;
        ram_rw_next    = ram_rw_reg;
        ram_addr_next  = ram_addr_reg;
        ram_wdata_next = ram_wdata_reg;
        done_next      = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    addr_next  = cmd_addr;
                    cnt_next   = cmd_len;
                    state_next = cmd_rw ? ST_READ : ST_WRITE;
                end
            end
            ST_WRITE: begin
                // A cycle without wr_valid is a gap: no RAM access, nothing advances.
                if (wr_valid) begin
                    ram_en_next    = 1'b1;
                    ram_rw_next    = 1'b0;
                    ram_addr_next  = addr_reg;
                    ram_wdata_next = wr_data;
                    addr_next      = addr_reg + ADDR_ONE;
                    cnt_next       = cnt_reg - ADDR_ONE;
                    if (cnt_reg == '0) begin
                        state_next = ST_FIN;
                    end
                end
            end
            ST_READ: begin
                // Reads never stall: one address per cycle until the count runs out.
                ram_en_next   = 1'b1;
                ram_rw_next   = 1'b1;
                ram_addr_next = addr_reg;
                addr_next     = addr_reg + ADDR_ONE;
                cnt_next      = cnt_reg - ADDR_ONE;
                if (cnt_reg == '0) begin
                    state_next = ST_FIN;
                end
            end
            ST_FIN: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State, burst pointer/counter and registered RAM pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            addr_reg      <= '0;
            cnt_reg       <= '0;
            ram_en_reg    <= 1'b0;
            ram_rw_reg    <= 1'b1;
            ram_addr_reg  <= '0;
            ram_wdata_reg <= '0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            addr_reg      <= addr_next;
            cnt_reg       <= cnt_next;
            ram_en_reg    <= ram_en_next;
            ram_rw_reg    <= ram_rw_next;
            ram_addr_reg  <= ram_addr_next;
            ram_wdata_reg <= ram_wdata_next;
            done_reg      <= done_next;
        end
    end

    // Capture RAM read data only after a read-enabled cycle, so undefined RAM output never leaks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_data_reg  <= '0;
        end else begin
            rd_valid_reg <= ram_en_reg && ram_rw_reg;
            if (ram_en_reg && ram_rw_reg) begin
                rd_data_reg <= ram_rdata;
            end
        end
    end

endmodule
